// File: rtl/mul_final_add_pkg.sv
// mul_final_add_pkg
//   Shared definitions for the multiplier final-add stage: result-select
//   encodings, the product width and the default tag/result widths.
package mul_final_add_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int PROD_W    = 2 * XLEN_DEF;
  localparam int TAG_W_DEF = 5;

  // Result field selection; RES_RSVD behaves like RES_LOW.
  typedef enum logic [1:0] {
    RES_LOW  = 2'b00,
    RES_HIGH = 2'b01,
    RES_WORD = 2'b10,
    RES_RSVD = 2'b11
  } res_sel_e;

endpackage

// File: rtl/mul_add64.sv
// mul_add64
//   Carry-propagate adder with carry-in and carry-out. Used for the low and
//   high halves of the 128-bit product resolution.
// Ports:
//   a, b  in  W  addends
//   cin   in  1  carry in
//   sum   out W  a + b + cin (mod 2^W)
//   cout  out 1  carry out of bit W-1
module mul_add64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full_s;

  assign full_s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign {cout, sum} = full_s;

endmodule

// File: rtl/mul_final_add.sv
// mul_final_add
//   Final stage of the 64x64 Booth/Wallace multiplier. Resolves the
//   column-aligned sum and carry vectors with a carry-propagate add, selects
//   the MUL / MULH* / MULW field and presents it over valid/ready.
//
//   Default build: two pipeline stages. Stage 1 adds the low halves and
//   registers the carry-out together with the raw high halves; stage 2 adds
//   the high halves plus that carry and registers the selected result.
//   With MUL_SINGLE_CYCLE_ADD_EN defined: one stage, the full 128-bit add and
//   select sit in front of the output register (latency 1).
//
// Ports:
//   clk          in   1       clock
//   rst          in   1       synchronous active-high reset
//   flush_i      in   1       kill all in-flight operations
//   in_valid_i   in   1       upstream sum/carry vectors valid
//   in_ready_o   out  1       stage can accept this cycle
//   s_vec_i      in   2*XLEN  Wallace sum vector
//   c_vec_i      in   2*XLEN  Wallace carry vector (already aligned)
//   res_sel_i    in   2       00 low, 01 high, 10 word sign-extended, 11 as 00
//   tag_i        in   TAG_W   destination tag
//   out_valid_o  out  1       result valid
//   out_ready_i  in   1       consumer accepts result
//   result_o     out  XLEN    selected result
//   tag_o        out  TAG_W   tag of result
module mul_final_add
  import mul_final_add_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2*XLEN-1:0] s_vec_i,
  input  logic [2*XLEN-1:0] c_vec_i,
  input  logic [1:0]        res_sel_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic              v2_r;
  logic [XLEN-1:0]   result_r;
  logic [TAG_W-1:0]  tag2_r;

  logic              in_ready_s;
  logic              acc_s;
  logic              ld2_s;
  logic [XLEN-1:0]   lo_src_s;
  logic [XLEN-1:0]   hi_src_s;
  logic [1:0]        sel_src_s;
  logic [TAG_W-1:0]  tag_src_s;
  logic [XLEN-1:0]   sel_res_s;

  logic [XLEN-1:0]   lo_sum_s;
  logic              lo_cout_s;
  logic [XLEN-1:0]   hi_sum_s;
  logic              hi_cout_unused_s;

`ifndef MUL_SINGLE_CYCLE_ADD_EN

  logic              v1_r;
  logic [XLEN-1:0]   lo_r;
  logic              k_r;
  logic [XLEN-1:0]   s_hi_r;
  logic [XLEN-1:0]   c_hi_r;
  logic [1:0]        sel1_r;
  logic [TAG_W-1:0]  tag1_r;
  logic              adv2_s;

  mul_add64 #(.W(XLEN)) u_add_lo (
    .a    (s_vec_i[XLEN-1:0]),
    .b    (c_vec_i[XLEN-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum_s),
    .cout (lo_cout_s)
  );

  // High half sees the low-half carry captured in stage 1.
  mul_add64 #(.W(XLEN)) u_add_hi (
    .a    (s_hi_r),
    .b    (c_hi_r),
    .cin  (k_r),
    .sum  (hi_sum_s),
    .cout (hi_cout_unused_s)
  );

  assign adv2_s     = v1_r && (!v2_r || out_ready_i);
  assign in_ready_s = !v1_r || adv2_s;
  assign acc_s      = in_valid_i && in_ready_s;
  assign ld2_s      = adv2_s;
  assign lo_src_s   = lo_r;
  assign hi_src_s   = hi_sum_s;
  assign sel_src_s  = sel1_r;
  assign tag_src_s  = tag1_r;

  // Stage 1: low-half sum, its carry-out and the raw high halves.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r   <= 1'b0;
      lo_r   <= '0;
      k_r    <= 1'b0;
      s_hi_r <= '0;
      c_hi_r <= '0;
      sel1_r <= 2'b00;
      tag1_r <= '0;
    end else if (flush_i) begin
      v1_r <= 1'b0;
    end else if (acc_s) begin
      v1_r   <= 1'b1;
      lo_r   <= lo_sum_s;
      k_r    <= lo_cout_s;
      s_hi_r <= s_vec_i[2*XLEN-1:XLEN];
      c_hi_r <= c_vec_i[2*XLEN-1:XLEN];
      sel1_r <= res_sel_i;
      tag1_r <= tag_i;
    end else if (adv2_s) begin
      v1_r <= 1'b0;
    end else begin
      v1_r <= v1_r;
    end
  end

`else

  mul_add64 #(.W(XLEN)) u_add_lo (
    .a    (s_vec_i[XLEN-1:0]),
    .b    (c_vec_i[XLEN-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum_s),
    .cout (lo_cout_s)
  );

  // Chained directly: full 128-bit ripple between the halves in one cycle.
  mul_add64 #(.W(XLEN)) u_add_hi (
    .a    (s_vec_i[2*XLEN-1:XLEN]),
    .b    (c_vec_i[2*XLEN-1:XLEN]),
    .cin  (lo_cout_s),
    .sum  (hi_sum_s),
    .cout (hi_cout_unused_s)
  );

  assign in_ready_s = !v2_r || out_ready_i;
  assign acc_s      = in_valid_i && in_ready_s;
  assign ld2_s      = acc_s;
  assign lo_src_s   = lo_sum_s;
  assign hi_src_s   = hi_sum_s;
  assign sel_src_s  = res_sel_i;
  assign tag_src_s  = tag_i;

`endif

  // Result field select; the reserved encoding falls back to the low half.
  always_comb begin
    sel_res_s = lo_src_s;
    case (res_sel_e'(sel_src_s))
      RES_HIGH: sel_res_s = hi_src_s;
      RES_WORD: sel_res_s = {{(XLEN-32){lo_src_s[31]}}, lo_src_s[31:0]};
      RES_LOW:  sel_res_s = lo_src_s;
      RES_RSVD: sel_res_s = lo_src_s;
      default:  sel_res_s = lo_src_s;
    endcase
  end

  // Output stage: holds result and tag stable until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r     <= 1'b0;
      result_r <= '0;
      tag2_r   <= '0;
    end else if (flush_i) begin
      v2_r <= 1'b0;
    end else if (ld2_s) begin
      v2_r     <= 1'b1;
      result_r <= sel_res_s;
      tag2_r   <= tag_src_s;
    end else if (out_ready_i) begin
      v2_r <= 1'b0;
    end else begin
      v2_r <= v2_r;
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = v2_r;
  assign result_o    = result_r;
  assign tag_o       = tag2_r;

endmodule

// File: tb/tb_mul_final_add.sv
// Self-checking bench for mul_final_add (either build, MUL_SINGLE_CYCLE_ADD_EN
// selects the single-cycle variant). Expected results come from a plain
// 128-bit addition and field extraction, queued at accept time and compared
// by an independent output monitor.
module tb_mul_final_add;

  localparam int TAG_W = 5;
`ifdef MUL_SINGLE_CYCLE_ADD_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] s_vec_i;
  logic [127:0] c_vec_i;
  logic [1:0]   res_sel_i;
  logic [4:0]   tag_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [63:0]  result_o;
  logic [4:0]   tag_o;

  mul_final_add #(.TAG_W(TAG_W), .XLEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .s_vec_i     (s_vec_i),
    .c_vec_i     (c_vec_i),
    .res_sel_i   (res_sel_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .tag_o       (tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   strict_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole product by plain 128-bit addition, then pick the field.
  function automatic logic [63:0] ref_res(input logic [127:0] s, input logic [127:0] c,
                                          input logic [1:0] sel);
    logic [127:0] p;
    p = s + c;
    if (sel == 2'd1) return p[127:64];
    else if (sel == 2'd2) return {{32{p[31]}}, p[31:0]};
    else return p[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus side of the scoreboard: record every accepted operation.
  always @(negedge clk) begin
    #2;
    if (!rst && !flush_i && in_valid_i && in_ready_o)
      sbq.push_back('{ref_res(s_vec_i, c_vec_i, res_sel_i), tag_i, cyc});
  end

  // Output monitor: hold stability, in-order result/tag, latency; flush/reset empty the queue.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_res;
  logic [4:0]  prev_tag;
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    #3;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid_o), 64'd1);
      chk("hold_result", result_o, prev_res);
      chk("hold_tag", 64'(tag_o), 64'(prev_tag));
    end
    prev_stall = !rst && !flush_i && out_valid_o && !out_ready_i;
    prev_res   = result_o;
    prev_tag   = tag_o;
    if (!rst && out_valid_o && out_ready_i) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output_valid", 64'(out_valid_o), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("result", result_o, e.res);
        chk("tag", 64'(tag_o), 64'(e.tag));
        lat = cyc - e.acc;
        if (strict_lat) chk("latency", 64'(lat), 64'(LAT));
        else chk("latency_min", 64'(lat >= LAT), 64'd1);
      end
    end
    if (rst || flush_i) sbq.delete();
  end

  task automatic apply(input logic v, input logic [127:0] s, input logic [127:0] c,
                       input logic [1:0] sel, input logic [4:0] tag, input logic rdy,
                       input logic fl, output bit acc);
    @(negedge clk);
    in_valid_i  = v;
    s_vec_i     = s;
    c_vec_i     = c;
    res_sel_i   = sel;
    tag_i       = tag;
    out_ready_i = rdy;
    flush_i     = fl;
    #2;
    acc = v && !fl && !rst && in_ready_o;
  endtask

  task automatic idle(input int n, input logic rdy);
    bit a;
    for (int i = 0; i < n; i++) apply(1'b0, 128'd0, 128'd0, 2'd0, 5'd0, rdy, 1'b0, a);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit a;
    int nacc;
    logic [4:0] t;
    logic [127:0] s, c;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    s_vec_i = 128'd0; c_vec_i = 128'd0; res_sel_i = 2'd0; tag_i = 5'd0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_out_valid", 64'(out_valid_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_tag", 64'(tag_o), 64'd0);
    chk("reset_in_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed results with an always-ready consumer.
    strict_lat = 1'b1;
    apply(1'b1, 128'd15, 128'd0, 2'b00, 5'd7, 1'b1, 1'b0, a);
    apply(1'b1, 128'h1_FFFFFFFF_FFFFFFFF, 128'd1, 2'b01, 5'd3, 1'b1, 1'b0, a);
    apply(1'b1, 128'h1_FFFFFFFF_FFFFFFFF, 128'd1, 2'b00, 5'd4, 1'b1, 1'b0, a);
    apply(1'b1, 128'h80000000, 128'd0, 2'b10, 5'd5, 1'b1, 1'b0, a);
    apply(1'b1, 128'd5, 128'd0, 2'b11, 5'd6, 1'b1, 1'b0, a);
    idle(4, 1'b1);
    chk("directed_drained", 64'(sbq.size()), 64'd0);

    // Backpressure: consumer stalled for four cycles, tags 1,2,3 offered.
    strict_lat = 1'b0;
    t = 5'd1; nacc = 0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, rnd128(), rnd128(), 2'($urandom_range(0, 3)), t, 1'b0, 1'b0, a);
      if (a) begin t++; nacc++; end
    end
    chk("bp_accepted", 64'(nacc), 64'(LAT));
    chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
    chk("bp_head_valid", 64'(out_valid_o), 64'd1);
    chk("bp_head_tag", 64'(tag_o), 64'd1);
    for (int i = 0; i < 20 && t <= 5'd3; i++) begin
      apply(1'b1, rnd128(), rnd128(), 2'($urandom_range(0, 3)), t, 1'b1, 1'b0, a);
      if (a) t++;
    end
    idle(6, 1'b1);
    chk("bp_drained", 64'(sbq.size()), 64'd0);

    // Flush with operations in flight and a third presented alongside it.
    apply(1'b1, rnd128(), rnd128(), 2'd1, 5'd10, 1'b0, 1'b0, a);
    apply(1'b1, rnd128(), rnd128(), 2'd0, 5'd11, 1'b0, 1'b0, a);
    apply(1'b1, rnd128(), rnd128(), 2'd2, 5'd12, 1'b0, 1'b1, a);
    apply(1'b0, 128'd0, 128'd0, 2'd0, 5'd0, 1'b0, 1'b0, a);
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_in_ready", 64'(in_ready_o), 64'd1);
    strict_lat = 1'b1;
    apply(1'b1, 128'hFFFF_0000_0000_0000_1234, 128'h1, 2'd1, 5'd9, 1'b1, 1'b0, a);
    chk("post_flush_accept", 64'(a), 64'd1);
    idle(4, 1'b1);
    chk("flush_drained", 64'(sbq.size()), 64'd0);

    // Reset in the middle of a stalled stream.
    strict_lat = 1'b0;
    apply(1'b1, rnd128(), rnd128(), 2'd0, 5'd20, 1'b0, 1'b0, a);
    apply(1'b1, rnd128(), rnd128(), 2'd1, 5'd21, 1'b0, 1'b0, a);
    @(negedge clk);
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_mid_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    chk("rst_mid_tag", 64'(tag_o), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready_o), 64'd1);

    // Randomized traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      s = rnd128();
      c = rnd128();
      if ($urandom_range(0, 3) == 0) begin
        s[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        c[63:0] = 64'($urandom_range(1, 3));
      end
      apply($urandom_range(0, 9) < 7, s, c, 2'($urandom_range(0, 3)), 5'($urandom()),
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, a);
    end
    for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);
    chk("final_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
